anc_frame_sequencer: RTL and testbench

//  Per-sample scheduler for the ANC datapath: lowpass -> LMS weight update -> 63-tap FIR.
//  - Each accepted mic sample launches the stages in strict order and waits for each done.
//  - Replaces direct done->ready chaining, so LMS and FIR never overlap and coefficients
//    are stable during FIR.
//  - Drops and counts samples that arrive while a frame is in flight.

---
 rtl/anc_frame_sequencer.sv | 109 ++++++++++
 tb/tb_anc_frame_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/anc_frame_sequencer.sv
// anc_frame_sequencer: per-sample lowpass -> LMS -> FIR scheduler with overrun counting; optional stage watchdog via SEQ_WATCHDOG_EN
module anc_frame_sequencer #(
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int OVR_CNT_W      = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 sample_ready_in,
    input  logic                 nc_on_in,
    input  logic                 adapt_en_in,
    input  logic                 lowpass_done_in,
    input  logic                 lms_done_in,
    input  logic                 fir_done_in,
    output logic                 lowpass_start_out,
    output logic                 lms_start_out,
    output logic                 fir_start_out,
    output logic                 y_valid_out,
    output logic                 bypass_out,
    output logic                 busy_out,
    output logic                 overrun_out,
    output logic [OVR_CNT_W-1:0] overrun_count_out,
    output logic                 timeout_out
);
    typedef enum logic [2:0] {IDLE, LP_WAIT, LMS_WAIT, FIR_WAIT, DONE} state_t;
    state_t state, state_nx;
    logic nc_q, adapt_q;
    logic lp_go, lms_go, fir_go, ovr_go;
    logic lp_ok, lms_ok, fir_ok, in_wait, wd_hit;
    assign in_wait = state inside {LP_WAIT, LMS_WAIT, FIR_WAIT};
    assign lp_ok   = lowpass_done_in && !lowpass_start_out;
    assign lms_ok  = lms_done_in && !lms_start_out;
    assign fir_ok  = fir_done_in && !fir_start_out;
`ifdef SEQ_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    assign wd_hit = in_wait && wd_cnt == CW'(TIMEOUT_CYCLES - 1);
    // stage watchdog: restart on every state change, sticky flag when a wait gives up
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wd_cnt      <= '0;
            timeout_out <= 1'b0;
        end else begin
            wd_cnt      <= (state_nx != state) ? '0 : wd_cnt + 1'b1;
            timeout_out <= timeout_out | (wd_hit && state_nx == IDLE);
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign timeout_out = 1'b0;
`endif
    // next state and start requests; a done on the last watchdog cycle takes priority
    always_comb begin
        state_nx = state;
        lp_go    = 1'b0;
        lms_go   = 1'b0;
        fir_go   = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nx = sample_ready_in ? LP_WAIT : IDLE;
                lp_go    = sample_ready_in;
            end
            LP_WAIT:
                if (lp_ok) begin
                    state_nx = !nc_q ? DONE : adapt_q ? LMS_WAIT : FIR_WAIT;
                    lms_go   = nc_q && adapt_q;
                    fir_go   = nc_q && !adapt_q;
                end else if (wd_hit) state_nx = IDLE;
            LMS_WAIT:
                if (lms_ok) begin
                    state_nx = FIR_WAIT;
                    fir_go   = 1'b1;
                end else if (wd_hit) state_nx = IDLE;
            FIR_WAIT:
                state_nx = fir_ok ? DONE : wd_hit ? IDLE : FIR_WAIT;
            default: state_nx = IDLE;
        endcase
        ovr_go = sample_ready_in && in_wait;
    end
    // state register, registered pulses, frame-latched modes and saturating drop counter
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= IDLE;
            lowpass_start_out <= 1'b0;
            lms_start_out     <= 1'b0;
            fir_start_out     <= 1'b0;
            y_valid_out       <= 1'b0;
            busy_out          <= 1'b0;
            overrun_out       <= 1'b0;
            bypass_out        <= 1'b0;
            nc_q              <= 1'b0;
            adapt_q           <= 1'b0;
            overrun_count_out <= '0;
        end else begin
            state             <= state_nx;
            lowpass_start_out <= lp_go;
            lms_start_out     <= lms_go;
            fir_start_out     <= fir_go;
            y_valid_out       <= state_nx == DONE;
            busy_out          <= state_nx != IDLE;
            overrun_out       <= ovr_go;
            if (lp_go) begin
                nc_q       <= nc_on_in;
                adapt_q    <= adapt_en_in;
                bypass_out <= !nc_on_in;
            end
            if (ovr_go && !(&overrun_count_out)) overrun_count_out <= overrun_count_out + 1'b1;
        end
    end
endmodule

// File: tb/tb_anc_frame_sequencer.sv
// tb_anc_frame_sequencer: scoreboard bench for anc_frame_sequencer
module tb_anc_frame_sequencer;
    localparam int OW = 8;
    localparam logic [4:0] EV_LP = 5'b00001, EV_LMS = 5'b00010, EV_FIR = 5'b00100,
                           EV_YV = 5'b01000, EV_OVR = 5'b10000;
    localparam int L_BUSY = 0, L_BYP = 1, L_CNT = 2, L_TO = 3, L_ALL = 4;
    typedef struct { int cyc; logic [4:0] ev; } pe_t;
    typedef struct { int cyc; int sel; int val; } le_t;
    logic clk = 0, rst_n = 0, sr = 0, nc = 0, ad = 0, lpd = 0, lmsd = 0, frd = 0;
    logic lp, lms, fir, yv, byp, busy, ovr, to;
    logic [OW-1:0] cnt;
    int cyc = 0;
    int checks = 0, failures = 0;
    bit fin = 0;
    pe_t q[$];
    le_t lq[$];
    pe_t e;
    le_t l;
    logic [4:0] pv;

    anc_frame_sequencer #(.TIMEOUT_CYCLES(16), .OVR_CNT_W(OW)) dut (
        .clk_in(clk), .rst_in(rst_n), .sample_ready_in(sr), .nc_on_in(nc), .adapt_en_in(ad),
        .lowpass_done_in(lpd), .lms_done_in(lmsd), .fir_done_in(frd),
        .lowpass_start_out(lp), .lms_start_out(lms), .fir_start_out(fir), .y_valid_out(yv),
        .bypass_out(byp), .busy_out(busy), .overrun_out(ovr), .overrun_count_out(cnt),
        .timeout_out(to)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int act(input int sel);
        case (sel)
            L_BUSY:  return int'(busy);
            L_BYP:   return int'(byp);
            L_CNT:   return int'(cnt);
            L_TO:    return int'(to);
            default: return int'({lp, lms, fir, yv, byp, busy, ovr, to, cnt});
        endcase
    endfunction

    // monitor: pulses against the event queue, levels against the level queue
    always @(negedge clk) begin
        pv = {ovr, yv, fir, lms, lp};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_pulse cyc=%0d got=none want=%b", e.cyc, e.ev);
        end
        if (pv != 0 || (q.size() > 0 && q[0].cyc == cyc)) begin
            checks++;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                if (e.ev != pv) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d got=%b want=%b", cyc, pv, e.ev);
                end
            end else begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b want=00000", cyc, pv);
            end
        end
        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
            l = lq.pop_front();
            checks++;
            if (act(l.sel) != l.val) begin
                failures++;
                $display("FAIL level sel=%0d cyc=%0d got=%0d want=%0d", l.sel, cyc, act(l.sel), l.val);
            end
        end
        if (fin) begin
            checks++;
            if (q.size() != 0 || lq.size() != 0) begin
                failures++;
                $display("FAIL leftover_expect got=%0d want=0", q.size() + lq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic a, input logic b, input logic c, input logic [4:0] ev);
        sr = s; lpd = a; lmsd = b; frd = c;
        if (ev != 0) q.push_back(pe_t'{cyc + 1, ev});
        tick;
        sr = 0; lpd = 0; lmsd = 0; frd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick;
    endtask

    task automatic lv(input int sel, input int val);
        lq.push_back(le_t'{cyc, sel, val});
    endtask

    initial begin
        #1;
        lv(L_ALL, 0);
        idle(2);
        rst_n = 1;
        idle(2);
        // full adaptive frame; mode inputs flipped mid-frame must not matter
        nc = 1; ad = 1;
        step(1, 0, 0, 0, EV_LP);
        lv(L_BUSY, 1);
        nc = 0; ad = 0;
        idle(4);
        step(0, 1, 0, 0, EV_LMS);
        idle(69);
        step(0, 0, 1, 0, EV_FIR);
        idle(69);
        step(0, 0, 0, 1, EV_YV);
        idle(2);
        lv(L_BUSY, 0);
        lv(L_BYP, 0);
        // bypass frame
        nc = 0;
        step(1, 0, 0, 0, EV_LP);
        idle(4);
        step(0, 1, 0, 0, EV_YV);
        lv(L_BYP, 1);
        lv(L_BUSY, 1);
        idle(2);
        // frozen weights; stray lms_done in FIR_WAIT ignored
        nc = 1; ad = 0;
        step(1, 0, 0, 0, EV_LP);
        lv(L_BYP, 0);
        idle(2);
        step(0, 1, 0, 0, EV_FIR);
        step(0, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 1, EV_YV);
        idle(2);
        // overruns during LMS_WAIT; done in the start cycle is ignored
        nc = 1; ad = 1;
        step(1, 0, 0, 0, EV_LP);
        step(0, 1, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0, EV_LMS);
        idle(1);
        step(1, 0, 0, 0, EV_OVR);
        idle(1);
        step(1, 0, 0, 0, EV_OVR);
        step(1, 0, 0, 0, EV_OVR);
        idle(1);
        lv(L_CNT, 3);
        step(0, 0, 1, 0, EV_FIR);
        idle(1);
        step(0, 0, 0, 1, EV_YV);
        idle(2);
        // counter saturation
        step(1, 0, 0, 0, EV_LP);
        idle(1);
        step(0, 1, 0, 0, EV_LMS);
        repeat (261) step(1, 0, 0, 0, EV_OVR);
        idle(1);
        lv(L_CNT, 255);
        step(0, 0, 1, 0, EV_FIR);
        idle(1);
        step(0, 0, 0, 1, EV_YV);
        idle(2);
        // back-to-back accept in DONE, then spurious dones in IDLE
        nc = 0;
        step(1, 0, 0, 0, EV_LP);
        idle(2);
        step(0, 1, 0, 0, EV_YV);
        step(1, 0, 0, 0, EV_LP);
        idle(1);
        step(0, 1, 0, 0, EV_YV);
        idle(2);
        step(0, 1, 1, 1, 0);
        idle(1);
        lv(L_BUSY, 0);
        lv(L_CNT, 255);
`ifdef SEQ_WATCHDOG_EN
        nc = 1; ad = 0;
        step(1, 0, 0, 0, EV_LP);
        idle(1);
        step(0, 1, 0, 0, EV_FIR);
        idle(20);
        lv(L_TO, 1);
        lv(L_BUSY, 0);
        idle(2);
`else
        lv(L_TO, 0);
`endif
        // async reset in LMS_WAIT clears everything at once
        nc = 1; ad = 1;
        step(1, 0, 0, 0, EV_LP);
        idle(1);
        step(0, 1, 0, 0, EV_LMS);
        idle(2);
        rst_n = 0;
        lv(L_ALL, 0);
        idle(1);
        rst_n = 1;
        idle(3);
        lv(L_ALL, 0);
        step(1, 0, 0, 0, EV_LP);
        idle(1);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, EV_LMS);
        idle(1);
        step(0, 0, 1, 0, EV_FIR);
        idle(1);
        step(0, 0, 0, 1, EV_YV);
        idle(2);
        lv(L_CNT, 0);
        lv(L_BUSY, 0);
        idle(1);
        fin = 1;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
